// File: rtl/cond_exec_unit.sv
// Condition-execute stage: holds the architectural NZCV flags, checks each Execute
// instruction's ARM condition against them, and registers the gated enables into M.
module cond_exec_unit #(
   parameter logic [3:0] FLAG_RESET = 4'b0000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       valid_e,
   input  logic [3:0] cond_e,
   input  logic [3:0] alu_flags_e,
   input  logic [1:0] flag_write_e,
   input  logic       reg_write_e,
   input  logic       mem_write_e,
   input  logic       pc_src_e,
   input  logic       stall,
   input  logic       flush,
   output logic       cond_ex_e,
   output logic       branch_taken_e,
   output logic       reg_write_m,
   output logic       mem_write_m,
   output logic       valid_m,
   output logic [3:0] flags_q
);

   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_pass;
   logic flag_update;

   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_c = flags_q[1];
   assign flag_v = flags_q[0];

   // The decode deliberately reads the stored flags, not the ALU's current output.
   always_comb begin
      cond_pass = 1'b1;
      case (cond_e)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = ~flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = ~flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = ~flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = ~flag_v;
         4'b1000: cond_pass = flag_c & ~flag_z;
         4'b1001: cond_pass = ~flag_c | flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_pass = flag_z | (flag_n != flag_v);
         default: cond_pass = 1'b1;
      endcase
   end

   assign cond_ex_e      = valid_e & cond_pass;
   assign branch_taken_e = pc_src_e & cond_ex_e;
   assign flag_update    = cond_ex_e & ~stall & ~flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= FLAG_RESET;
      end else if (flag_update) begin
         if (flag_write_e[1]) flags_q[3:2] <= alu_flags_e[3:2];
         if (flag_write_e[0]) flags_q[1:0] <= alu_flags_e[1:0];
      end
   end

   // Flush takes priority over stall so the hazard unit can always force a bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_write_m <= 1'b0;
         mem_write_m <= 1'b0;
         valid_m     <= 1'b0;
      end else if (flush) begin
         reg_write_m <= 1'b0;
         mem_write_m <= 1'b0;
         valid_m     <= 1'b0;
      end else if (!stall) begin
         reg_write_m <= reg_write_e & cond_ex_e;
         mem_write_m <= mem_write_e & cond_ex_e;
         valid_m     <= valid_e;
      end
   end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed-vector bench for cond_exec_unit with hand-computed expectations.
module tb_cond_exec_unit;

   logic       clk;
   logic       reset_n;
   logic       valid_e;
   logic [3:0] cond_e;
   logic [3:0] alu_flags_e;
   logic [1:0] flag_write_e;
   logic       reg_write_e;
   logic       mem_write_e;
   logic       pc_src_e;
   logic       stall;
   logic       flush;
   logic       cond_ex_e;
   logic       branch_taken_e;
   logic       reg_write_m;
   logic       mem_write_m;
   logic       valid_m;
   logic [3:0] flags_q;

   int compared;
   int mismatched;

   cond_exec_unit #(.FLAG_RESET(4'b0000)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .valid_e        (valid_e),
      .cond_e         (cond_e),
      .alu_flags_e    (alu_flags_e),
      .flag_write_e   (flag_write_e),
      .reg_write_e    (reg_write_e),
      .mem_write_e    (mem_write_e),
      .pc_src_e       (pc_src_e),
      .stall          (stall),
      .flush          (flush),
      .cond_ex_e      (cond_ex_e),
      .branch_taken_e (branch_taken_e),
      .reg_write_m    (reg_write_m),
      .mem_write_m    (mem_write_m),
      .valid_m        (valid_m),
      .flags_q        (flags_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %b, expected %b at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] cond, input logic [3:0] alu,
                                input logic [1:0] fw, input logic rw, input logic mw,
                                input logic pc, input logic st, input logic fl);
      valid_e      = v;
      cond_e       = cond;
      alu_flags_e  = alu;
      flag_write_e = fw;
      reg_write_e  = rw;
      mem_write_e  = mw;
      pc_src_e     = pc;
      stall        = st;
      flush        = fl;
      #1;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Loads the flag register through an always-executed full flag write.
   task automatic loadFlags(input logic [3:0] value);
      applyStimulus(1'b1, 4'hE, value, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepClock();
      applyStimulus(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset_n    = 1'b0;
      applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepClock();
      stepClock();
      checkOutput("reset_flags", flags_q, 4'b0000);
      checkOutput("reset_rw_m", 4'(reg_write_m), 4'd0);
      checkOutput("reset_mw_m", 4'(mem_write_m), 4'd0);
      checkOutput("reset_valid_m", 4'(valid_m), 4'd0);
      reset_n = 1'b1;
      stepClock();
      checkOutput("post_reset_flags", flags_q, 4'b0000);

      applyStimulus(1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("eq_after_reset", 4'(cond_ex_e), 4'd0);
      applyStimulus(1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("ne_after_reset", 4'(cond_ex_e), 4'd1);

      // CMP setting Z, then a dependent BEQ in the very next cycle
      applyStimulus(1'b1, 4'hE, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("cmp_flags_not_early", flags_q, 4'b0000);
      stepClock();
      checkOutput("cmp_flags", flags_q, 4'b0100);
      checkOutput("cmp_valid_m", 4'(valid_m), 4'd1);
      applyStimulus(1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("beq_cond_ex", 4'(cond_ex_e), 4'd1);
      checkOutput("beq_taken", 4'(branch_taken_e), 4'd1);
      applyStimulus(1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("bne_not_taken", 4'(branch_taken_e), 4'd0);

      // Partial flag write keeps C and V
      loadFlags(4'b1111);
      checkOutput("load_1111", flags_q, 4'b1111);
      applyStimulus(1'b1, 4'hE, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepClock();
      checkOutput("partial_nz_write", flags_q, 4'b0011);
      applyStimulus(1'b1, 4'hE, 4'b1100, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepClock();
      checkOutput("partial_cv_write", flags_q, 4'b0000);

      // Failed condition suppresses every side effect except valid_m
      applyStimulus(1'b1, 4'h0, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("fail_cond_ex", 4'(cond_ex_e), 4'd0);
      stepClock();
      checkOutput("fail_rw_m", 4'(reg_write_m), 4'd0);
      checkOutput("fail_mw_m", 4'(mem_write_m), 4'd0);
      checkOutput("fail_valid_m", 4'(valid_m), 4'd1);
      checkOutput("fail_flags", flags_q, 4'b0000);

      // Signed and unsigned compares
      loadFlags(4'b1000);
      applyStimulus(1'b1, 4'hA, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("ge_n1v0", 4'(cond_ex_e), 4'd0);
      applyStimulus(1'b1, 4'hB, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lt_n1v0", 4'(cond_ex_e), 4'd1);
      applyStimulus(1'b1, 4'hC, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("gt_n1v0", 4'(cond_ex_e), 4'd0);
      applyStimulus(1'b1, 4'hD, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("le_n1v0", 4'(cond_ex_e), 4'd1);
      applyStimulus(1'b1, 4'h4, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mi_n1", 4'(cond_ex_e), 4'd1);
      loadFlags(4'b1001);
      applyStimulus(1'b1, 4'hA, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("ge_n1v1", 4'(cond_ex_e), 4'd1);
      applyStimulus(1'b1, 4'hC, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("gt_n1v1", 4'(cond_ex_e), 4'd1);
      applyStimulus(1'b1, 4'h6, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("vs_v1", 4'(cond_ex_e), 4'd1);
      loadFlags(4'b0110);
      applyStimulus(1'b1, 4'h8, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("hi_z1c1", 4'(cond_ex_e), 4'd0);
      applyStimulus(1'b1, 4'h9, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("ls_z1c1", 4'(cond_ex_e), 4'd1);
      applyStimulus(1'b1, 4'h2, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("cs_c1", 4'(cond_ex_e), 4'd1);
      applyStimulus(1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("cond_1111", 4'(cond_ex_e), 4'd1);

      // Bubble with an AL condition and write requests changes nothing
      applyStimulus(1'b0, 4'hE, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("bubble_cond_ex", 4'(cond_ex_e), 4'd0);
      checkOutput("bubble_branch", 4'(branch_taken_e), 4'd0);
      stepClock();
      checkOutput("bubble_flags", flags_q, 4'b0110);
      checkOutput("bubble_rw_m", 4'(reg_write_m), 4'd0);
      checkOutput("bubble_valid_m", 4'(valid_m), 4'd0);

      // Stall holds M and the flags; flush beats stall
      applyStimulus(1'b1, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      stepClock();
      checkOutput("pre_stall_rw_m", 4'(reg_write_m), 4'd1);
      applyStimulus(1'b1, 4'hE, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      stepClock();
      checkOutput("stall_rw_m", 4'(reg_write_m), 4'd1);
      checkOutput("stall_mw_m", 4'(mem_write_m), 4'd0);
      checkOutput("stall_valid_m", 4'(valid_m), 4'd1);
      checkOutput("stall_flags", flags_q, 4'b0110);
      applyStimulus(1'b1, 4'hE, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      stepClock();
      checkOutput("flush_rw_m", 4'(reg_write_m), 4'd0);
      checkOutput("flush_mw_m", 4'(mem_write_m), 4'd0);
      checkOutput("flush_valid_m", 4'(valid_m), 4'd0);
      checkOutput("flush_flags", flags_q, 4'b0110);

      // Asynchronous reset mid-cycle
      applyStimulus(1'b1, 4'hE, 4'b1010, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      stepClock();
      checkOutput("pre_areset_flags", flags_q, 4'b1010);
      checkOutput("pre_areset_mw_m", 4'(mem_write_m), 4'd1);
      applyStimulus(1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b0;
      #1;
      checkOutput("areset_flags", flags_q, 4'b0000);
      checkOutput("areset_rw_m", 4'(reg_write_m), 4'd0);
      checkOutput("areset_mw_m", 4'(mem_write_m), 4'd0);
      checkOutput("areset_valid_m", 4'(valid_m), 4'd0);
      checkOutput("areset_eq", 4'(cond_ex_e), 4'd0);
      stepClock();
      reset_n = 1'b1;
      stepClock();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/cond_exec_unit.md
Name: cond_exec_unit

Overview:
- Consumer end of the ALU flag interface: captures the ALU's NZCV flags into an architectural flag register.
- Evaluates each Execute-stage instruction's 4-bit ARM condition field against the stored flags.
- Gates that instruction's write and branch enables, and registers them into the Execute->Memory pipeline boundary.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- FLAG_RESET, 4'b0000, reset value of the NZCV flag register (bit order [3]=N [2]=Z [1]=C [0]=V).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- valid_e  input  1  Execute stage holds a real instruction (0 = bubble).
- cond_e  input  4  ARM condition field of the Execute instruction.
- alu_flags_e  input  4  NZCV from the ALU for the Execute instruction ([3]=N [2]=Z [1]=C [0]=V).
- flag_write_e  input  2  [1] = update N,Z; [0] = update C,V.
- reg_write_e  input  1  ungated register-write enable.
- mem_write_e  input  1  ungated memory-write enable.
- pc_src_e  input  1  ungated branch/PC-redirect request.
- stall  input  1  hold the flag register and M-stage outputs.
- flush  input  1  insert a bubble into the M stage.
- cond_ex_e  output  1  combinational: Execute instruction passes its condition and is valid.
- branch_taken_e  output  1  combinational: pc_src_e & cond_ex_e.
- reg_write_m  output  1  registered gated register-write enable.
- mem_write_m  output  1  registered gated memory-write enable.
- valid_m  output  1  registered: M stage holds a real instruction.
- flags_q  output  4  current architectural NZCV.

Behaviour:
- Reset (reset_n=0, asynchronous): flags_q=FLAG_RESET; reg_write_m=0, mem_write_m=0, valid_m=0. Combinational outputs follow from the reset state. Reset asserted mid-instruction discards that instruction's flag update and M-stage writes immediately.
- Condition decode uses flags_q (pre-update flags), never alu_flags_e:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C.
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 treated as 1.
- cond_ex_e = valid_e & decode(cond_e, flags_q). Zero latency, combinational.
- Flag update at rising edge, when cond_ex_e & ~stall & ~flush:
  - If flag_write_e[1]: N,Z <= alu_flags_e[3:2].
  - If flag_write_e[0]: C,V <= alu_flags_e[1:0].
  - Bits not selected hold. A failed condition never updates flags.
- M-stage register at rising edge:
  - flush=1: all M outputs <= 0. Flush wins over stall.
  - else stall=1: all M outputs hold.
  - else: reg_write_m <= reg_write_e & cond_ex_e; mem_write_m <= mem_write_e & cond_ex_e; valid_m <= valid_e.
- Latency: gated enables appear one cycle after the Execute cycle. Flag results are visible to the next instruction's condition check one cycle later (back-to-back CMP then BEQ works with no bubble).
- Bubbles (valid_e=0) never write flags or enables, regardless of cond_e or flag_write_e.
- branch_taken_e is not registered. The hazard unit uses it in the same cycle to flush Fetch/Decode.

Test Plan:
- Reset then release -> flags_q=0000, reg_write_m=0, mem_write_m=0, valid_m=0. cond_e=0000 (EQ) gives cond_ex_e=0; cond_e=0001 (NE) gives 1.
- CMP: valid_e=1, cond_e=1110, flag_write_e=11, alu_flags_e=0100 -> next cycle flags_q=0100. Then cond_e=0000, pc_src_e=1 -> branch_taken_e=1.
- Partial write: flags_q=1111, flag_write_e=10, alu_flags_e=0000, AL -> flags_q=0011 (C,V held).
- Failed condition: flags_q=0000, cond_e=0000, reg_write_e=1, mem_write_e=1, flag_write_e=11, alu_flags_e=1111 -> reg_write_m=0, mem_write_m=0, valid_m=1, flags_q stays 0000.
- Signed compares: flags_q=1000 (N=1,V=0) -> GE=0, LT=1, GT=0, LE=1. flags_q=1001 -> GE=1, GT=1. flags_q=0110 (Z=1,C=1) -> HI=0, LS=1.
- Stall/flush: M holds reg_write_m=1. stall=1 with a new flag-writing AL instruction -> M outputs and flags_q unchanged. stall=1 & flush=1 -> M outputs all 0, flags_q unchanged. Assert reset_n=0 between clock edges -> outputs clear without waiting for a clock edge.
